vga_pixel_pipe: RTL and testbench
=================================

// Module: vga_pixel_pipe
// PURPOSE
//  Sits directly downstream of the VGA timing generator and turns its address and sync stream into pixels.
//  Presents addr_lead to video RAM and maps each 8-bit pixel index through a 256x24 palette to VGA_R/G/B.
//  Delays HS/VS/BLANK_N so sync stays aligned with pixel data.
//  Host palette writes queue in a small FIFO and commit only during vertical sync, so a frame never tears.
// PARAMETERS
//  FIFO_DEPTH  4  palette-write FIFO entries (power of 2, >=2)
//  SYNC_DLY    2  cycles HS/VS/BLANK_N are delayed to match the RAM + palette read latency
// PORTS
//  clk25MHz      in   1   pixel clock
//  rst_n         in   1   asynchronous, active-low reset
//  blank_n_in    in   1   active-pixel strobe from the timing block
//  hs_in         in   1   active-low horizontal sync from the timing block
//  vs_in         in   1   active-low vertical sync from the timing block
//  addr_lead     in   19  video RAM address, leading the pixel by 1 cycle
//  vram_addr     out  19  read address to the video RAM (synchronous, 1-cycle latency)
//  vram_rd_data  in   8   palette index returned by the video RAM
//  pal_wr_valid  in   1   host palette write request
//  pal_wr_ready  out  1   FIFO can accept a write (= !full)
//  pal_wr_idx    in   8   palette entry to write
//  pal_wr_rgb    in   24  {R,G,B} value for that entry
//  pal_pending   out  1   FIFO non-empty (writes not yet committed)
//  VGA_R/G/B     out  8   colour outputs (three 8-bit ports)
//  VGA_HS/VS     out  1   delayed sync outputs
//  VGA_BLANK_N   out  1   delayed blank
//  VGA_SYNC_N    out  1   tied 0
// BEHAVIOUR
//  Reset values
//   - VGA_R/G/B=0; VGA_HS=VGA_VS=1; VGA_BLANK_N=0.
//   - FIFO empty, so pal_wr_ready=1 and pal_pending=0. FSM in IDLE.
//   - Palette RAM is not reset; its contents are undefined until written.
//   - The delay-line flops reset to HS=1, VS=1, BLANK_N=0.
//  Read path
//   - vram_addr = addr_lead (combinational).
//   - The palette is read on vram_rd_data with a registered read.
//   - VGA_R/G/B registered: the colour for the index at cycle t appears at t+1.
//   - RGB is forced to 0 whenever the delayed BLANK_N is 0.
//   - HS, VS and BLANK_N each pass through SYNC_DLY flops.
//  Host write
//   - A push happens when pal_wr_valid & pal_wr_ready.
//   - Pushes are accepted any cycle, including during an FSM drain.
//   - A push and a pop in the same cycle are legal; occupancy is unchanged.
//   - When full, pal_wr_ready=0 and the host holds its request.
//  FSM
//   - IDLE -> WAIT_VS when pal_pending=1 and vs_in=1.
//   - IDLE -> DRAIN when pal_pending=1 and vs_in=0.
//   - WAIT_VS -> DRAIN on the first cycle vs_in=0.
//   - DRAIN: pops one entry per cycle and writes palette[idx] = rgb.
//   - DRAIN -> IDLE when the FIFO is empty.
//   - DRAIN -> WAIT_VS if vs_in rises with entries left; the remainder waits for the next frame.
//   - Palette writes never occur while vs_in=1, so active-video reads are never disturbed.
//  Boundary conditions
//   - FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.
//   - Full and empty are distinguished by the pointer MSB.
//   - Several writes to the same idx commit in order; the last one wins.
//   - rst_n asserted mid-drain discards all queued entries.
//   - Palette entries already committed keep their value through that reset.
// TESTING
//  1. Reset: assert rst_n low mid-frame -> RGB=0, HS=VS=1, BLANK_N=0, pal_wr_ready=1, pal_pending=0.
//  2. Latency: write pal[0x12]=0xFF8000 and commit in vsync, then drive vram_rd_data=0x12 with blank_n_in high
//     -> one cycle later RGB=FF/80/00, coincident with BLANK_N rising SYNC_DLY cycles after blank_n_in.
//  3. Deferral: push 3 writes while vs_in=1 -> pal_pending=1 and the palette is unchanged until vs_in falls;
//     then exactly 3 commits in 3 cycles and pal_pending drops.
//  4. Full: push 4 entries with vs_in=1 -> pal_wr_ready=0 after the 4th; a 5th push is held until the first pop.
//  5. Split drain: vs_in low for only 2 cycles with 4 entries queued -> 2 commit, FSM in WAIT_VS,
//     remaining 2 commit at the next vsync.
//  6. Blanking: vram_rd_data=0xFF with a non-zero palette entry and blank_n_in=0 -> RGB stays 0.

Source files
------------

// File: rtl/vga_pixel_pipe.sv
// Pixel back end for the VGA timing generator: video RAM index -> 256x24 palette -> RGB,
// with sync delayed to match, and host palette writes deferred to vertical sync.
module vga_pixel_pipe #(
    parameter int FIFO_DEPTH = 4,
    parameter int SYNC_DLY   = 2
) (
    input  logic        clk25MHz,
    input  logic        rst_n,
    input  logic        blank_n_in,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic [18:0] addr_lead,
    output logic [18:0] vram_addr,
    input  logic [7:0]  vram_rd_data,
    input  logic        pal_wr_valid,
    output logic        pal_wr_ready,
    input  logic [7:0]  pal_wr_idx,
    input  logic [23:0] pal_wr_rgb,
    output logic        pal_pending,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PTR_W = AW + 1;

    typedef enum logic [1:0] {IDLE, WAIT_VS, DRAIN} state_t;

    state_t           state;
    logic [23:0]      palette  [256];
    logic [7:0]       fifo_idx [FIFO_DEPTH];
    logic [23:0]      fifo_rgb [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             full, empty, push, pop;

    logic [SYNC_DLY-1:0] hs_dly, vs_dly, blank_dly;
    logic [23:0]         rgb_p1;

    assign vram_addr  = addr_lead;
    assign VGA_SYNC_N = 1'b0;

    // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
    assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty        = (wr_ptr == rd_ptr);
    assign pal_wr_ready = ~full;
    assign pal_pending  = ~empty;
    assign push         = pal_wr_valid & ~full;
    assign pop          = ~empty & ~vs_in & ((state == WAIT_VS) || (state == DRAIN));

    always_ff @(posedge clk25MHz) begin
        if (push) begin
            fifo_idx[wr_ptr[AW-1:0]] <= pal_wr_idx;
            fifo_rgb[wr_ptr[AW-1:0]] <= pal_wr_rgb;
        end
    end

    always_ff @(posedge clk25MHz) begin
        if (pop)
            palette[fifo_idx[rd_ptr[AW-1:0]]] <= fifo_rgb[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk25MHz or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Commit only while vs_in is low; a drain cut short by vs_in rising resumes next frame.
    always_ff @(posedge clk25MHz or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (!empty) state <= vs_in ? WAIT_VS : DRAIN;
                WAIT_VS: if (!vs_in) state <= DRAIN;
                DRAIN: begin
                    if (empty)      state <= IDLE;
                    else if (vs_in) state <= WAIT_VS;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sync delay line; SYNC_DLY must be at least 2 (RAM read + palette read).
    always_ff @(posedge clk25MHz or negedge rst_n) begin
        if (!rst_n) begin
            hs_dly    <= '1;
            vs_dly    <= '1;
            blank_dly <= '0;
        end else begin
            hs_dly    <= {hs_dly[SYNC_DLY-2:0], hs_in};
            vs_dly    <= {vs_dly[SYNC_DLY-2:0], vs_in};
            blank_dly <= {blank_dly[SYNC_DLY-2:0], blank_n_in};
        end
    end

    // Palette stage: gate with the blank bit entering the last delay flop so RGB and BLANK_N align.
    always_ff @(posedge clk25MHz or negedge rst_n) begin
        if (!rst_n)
            rgb_p1 <= '0;
        else
            rgb_p1 <= blank_dly[SYNC_DLY-2] ? palette[vram_rd_data] : 24'h0;
    end

    assign VGA_R       = rgb_p1[23:16];
    assign VGA_G       = rgb_p1[15:8];
    assign VGA_B       = rgb_p1[7:0];
    assign VGA_HS      = hs_dly[SYNC_DLY-1];
    assign VGA_VS      = vs_dly[SYNC_DLY-1];
    assign VGA_BLANK_N = blank_dly[SYNC_DLY-1];

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Scoreboard bench for vga_pixel_pipe: directed pixel and palette-write sequences,
// expected colours queued at issue and popped by a monitor whenever VGA_BLANK_N is high.
module tb_vga_pixel_pipe;

    logic        clk25MHz = 1'b0;
    logic        rst_n = 1'b1;
    logic        blank_n_in = 1'b0;
    logic        hs_in = 1'b1;
    logic        vs_in = 1'b1;
    logic [18:0] addr_lead = '0;
    logic [18:0] vram_addr;
    logic [7:0]  vram_rd_data = '0;
    logic        pal_wr_valid = 1'b0;
    logic        pal_wr_ready;
    logic [7:0]  pal_wr_idx = '0;
    logic [23:0] pal_wr_rgb = '0;
    logic        pal_pending;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;

    vga_pixel_pipe #(.FIFO_DEPTH(4), .SYNC_DLY(2)) dut (
        .clk25MHz(clk25MHz), .rst_n(rst_n), .blank_n_in(blank_n_in), .hs_in(hs_in), .vs_in(vs_in),
        .addr_lead(addr_lead), .vram_addr(vram_addr), .vram_rd_data(vram_rd_data),
        .pal_wr_valid(pal_wr_valid), .pal_wr_ready(pal_wr_ready), .pal_wr_idx(pal_wr_idx),
        .pal_wr_rgb(pal_wr_rgb), .pal_pending(pal_pending), .VGA_R(VGA_R), .VGA_G(VGA_G),
        .VGA_B(VGA_B), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_SYNC_N(VGA_SYNC_N)
    );

    always #5 clk25MHz = ~clk25MHz;

    // Video RAM model: content at an address is its low byte, one-cycle read latency.
    always @(posedge clk25MHz) vram_rd_data <= vram_addr[7:0];

    typedef struct {
        logic [7:0]  idx;
        logic [23:0] rgb;
    } wr_t;

    int          checks = 0;
    int          fails = 0;
    logic [23:0] sb[$];
    wr_t         mfifo[$];
    logic [23:0] model_pal [256];
    logic [2:0]  h0, h1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Input history {hs, vs, blank}: outputs must equal inputs sampled two edges back.
    always @(posedge clk25MHz or negedge rst_n) begin
        if (!rst_n) begin
            h0 <= 3'b110;
            h1 <= 3'b110;
        end else begin
            h0 <= {hs_in, vs_in, blank_n_in};
            h1 <= h0;
        end
    end

    always @(negedge clk25MHz) begin
        if (rst_n === 1'b1) begin
            check("hs_dly", 32'(VGA_HS), 32'(h1[2]));
            check("vs_dly", 32'(VGA_VS), 32'(h1[1]));
            check("blank_dly", 32'(VGA_BLANK_N), 32'(h1[0]));
            check("sync_n", 32'(VGA_SYNC_N), 32'(1'b0));
            if (VGA_BLANK_N === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL rgb_unexpected: got %0h, expected no active pixel at %0t",
                             {VGA_R, VGA_G, VGA_B}, $time);
                end else begin
                    logic [23:0] e;
                    e = sb.pop_front();
                    check("rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(e));
                end
            end else begin
                check("rgb_blank", 32'({VGA_R, VGA_G, VGA_B}), 32'(24'h0));
            end
        end
    end

    task automatic cyc(input logic b, input logic [7:0] idx, input logic vs);
        logic [18:0] a;
        @(posedge clk25MHz);
        #1;
        a          = {11'($urandom), idx};
        blank_n_in = b;
        addr_lead  = a;
        vs_in      = vs;
        hs_in      = ~b;
        if (b) sb.push_back(model_pal[idx]);
        #1 check("vram_addr", 32'(vram_addr), 32'(a));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b1);
    endtask

    task automatic push(input logic [7:0] idx, input logic [23:0] rgb);
        bit ok;
        wr_t w;
        @(posedge clk25MHz);
        #1;
        blank_n_in   = 1'b0;
        pal_wr_valid = 1'b1;
        pal_wr_idx   = idx;
        pal_wr_rgb   = rgb;
        ok = 1'b0;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk25MHz);
            if (pal_wr_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            fails++;
            $display("FAIL push_timeout: got ready=0 for 64 cycles, expected ready=1 (idx %0h)", idx);
        end else begin
            @(posedge clk25MHz);
            w.idx = idx;
            w.rgb = rgb;
            mfifo.push_back(w);
        end
        #1 pal_wr_valid = 1'b0;
    endtask

    // Hold vs_in low for n cycles; the queue head commits one entry per low cycle.
    task automatic vs_low(input int n);
        int k;
        wr_t w;
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        k = (n < mfifo.size()) ? n : mfifo.size();
        for (int i = 0; i < k; i++) begin
            w = mfifo.pop_front();
            model_pal[w.idx] = w.rgb;
        end
        check("pending_after_vs", 32'(pal_pending), 32'(mfifo.size() != 0));
        check("ready_after_vs", 32'(pal_wr_ready), 32'(mfifo.size() < 4));
    endtask

    task automatic do_reset();
        @(posedge clk25MHz);
        #1;
        rst_n        = 1'b0;
        blank_n_in   = 1'b0;
        vs_in        = 1'b1;
        hs_in        = 1'b1;
        pal_wr_valid = 1'b0;
        #1;
        check("rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(24'h0));
        check("rst_hs", 32'(VGA_HS), 32'(1'b1));
        check("rst_vs", 32'(VGA_VS), 32'(1'b1));
        check("rst_blank", 32'(VGA_BLANK_N), 32'(1'b0));
        check("rst_ready", 32'(pal_wr_ready), 32'(1'b1));
        check("rst_pending", 32'(pal_pending), 32'(1'b0));
        sb.delete();
        mfifo.delete();
        repeat (2) @(posedge clk25MHz);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation time limit, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        wr_t w;
        do_reset();

        // Initial palette contents.
        push(8'h20, 24'h111111);
        push(8'h21, 24'h222222);
        push(8'hFF, 24'h0A0B0C);
        push(8'h12, 24'h000001);
        vs_low(6);
        cyc(1'b1, 8'h20, 1'b1);
        cyc(1'b1, 8'h21, 1'b1);
        cyc(1'b1, 8'hFF, 1'b1);
        cyc(1'b0, 8'hFF, 1'b1);
        cyc(1'b1, 8'h12, 1'b1);
        idle(3);

        // Latency of a committed entry.
        push(8'h12, 24'hFF8000);
        check("pending_after_push", 32'(pal_pending), 32'(1'b1));
        vs_low(4);
        cyc(1'b1, 8'h12, 1'b1);
        idle(3);

        // Deferral: queued writes invisible until vs_in falls; same-index writes, last wins.
        push(8'h20, 24'hAAAAAA);
        push(8'h21, 24'hBBBBBB);
        push(8'h20, 24'hCCCCCC);
        check("pending_deferred", 32'(pal_pending), 32'(1'b1));
        cyc(1'b1, 8'h20, 1'b1);
        cyc(1'b1, 8'h21, 1'b1);
        idle(4);
        vs_low(3);
        cyc(1'b1, 8'h20, 1'b1);
        cyc(1'b1, 8'h21, 1'b1);
        idle(3);

        // Full FIFO: a fifth write is held until the first commit.
        push(8'h30, 24'h303030);
        push(8'h31, 24'h313131);
        push(8'h32, 24'h323232);
        push(8'h33, 24'h333333);
        check("ready_full", 32'(pal_wr_ready), 32'(1'b0));
        fork
            push(8'h34, 24'h343434);
            begin
                for (int i = 0; i < 3; i++) begin
                    cyc(1'b0, 8'h00, 1'b1);
                    check("ready_held", 32'(pal_wr_ready), 32'(1'b0));
                end
                vs_low(8);
            end
        join
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h30 + i), 1'b1);
        idle(3);

        // Split drain across two vertical syncs.
        push(8'h30, 24'hA0A0A0);
        push(8'h31, 24'hA1A1A1);
        push(8'h32, 24'hA2A2A2);
        push(8'h33, 24'hA3A3A3);
        vs_low(2);
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h30 + i), 1'b1);
        idle(3);
        vs_low(4);
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h30 + i), 1'b1);
        idle(3);

        // Reset with active pixels in flight.
        cyc(1'b1, 8'h20, 1'b1);
        cyc(1'b1, 8'h21, 1'b1);
        do_reset();
        idle(3);

        // Reset mid-drain: the one committed entry survives, the queued one is dropped.
        push(8'h20, 24'hDEAD00);
        push(8'h21, 24'hBEEF00);
        cyc(1'b0, 8'h00, 1'b0);
        w = mfifo.pop_front();
        model_pal[w.idx] = w.rgb;
        do_reset();
        vs_low(3);
        cyc(1'b1, 8'h20, 1'b1);
        cyc(1'b1, 8'h21, 1'b1);
        cyc(1'b1, 8'hFF, 1'b1);
        idle(4);
        check("sb_drained", 32'(sb.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
